exc_ctrl: RTL

Exception and interrupt controller in the MEM stage of the five-stage MIPS32 pipeline, directly upstream of the CP0 register file. Each cycle it inspects the instruction leaving MEM, the live CP0 Status/Cause/EPC values (with write-back forwarding), and the exception flags collected along the pipe. When it takes an exception or ERET, it produces:
- a registered pipeline flush with the redirect PC;
- a single-cycle CP0 update strobe carrying EPC, ExcCode, BD and the EXL set/clear.

---
 rtl/exc_ctrl_pkg.sv | 38 +++
 rtl/exc_prio_enc.sv | 54 +++++
 rtl/exc_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: CP0 register numbers,
// ExcCodes, trace encodings, exception vector, reset polarity and FSM states.
package exc_ctrl_pkg;

   localparam logic [4:0] Cp0RegStatus = 5'd12;
   localparam logic [4:0] Cp0RegCause  = 5'd13;
   localparam logic [4:0] Cp0RegEpc    = 5'd14;

   localparam logic [4:0] ExcCodeInt  = 5'h00;
   localparam logic [4:0] ExcCodeAdel = 5'h04;
   localparam logic [4:0] ExcCodeAdes = 5'h05;
   localparam logic [4:0] ExcCodeSys  = 5'h08;
   localparam logic [4:0] ExcCodeRi   = 5'h0a;
   localparam logic [4:0] ExcCodeOv   = 5'h0c;

   localparam logic [31:0] ExcTypeInt  = 32'h0000_0001;
   localparam logic [31:0] ExcTypeAdel = 32'h0000_0004;
   localparam logic [31:0] ExcTypeAdes = 32'h0000_0005;
   localparam logic [31:0] ExcTypeSys  = 32'h0000_0008;
   localparam logic [31:0] ExcTypeRi   = 32'h0000_000a;
   localparam logic [31:0] ExcTypeOv   = 32'h0000_000c;
   localparam logic [31:0] ExcTypeEret = 32'h0000_000e;

   localparam logic [31:0] ExcVectorDefault = 32'hBFC0_0380;

   localparam logic RstEnable = 1'b0;

   typedef enum logic [0:0] {
      StIdle,
      StFlush
   } exc_state_e;

   // Delay-slot instructions restart at the branch; subtraction wraps mod 2^32.
   function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic in_ds);
      return in_ds ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational exception priority encoder. Address-error inputs exist only
// when EXC_ADDR_ERR_EN is defined.
module exc_prio_enc
   import exc_ctrl_pkg::*;
(
   input  logic        int_pending_i,
`ifdef EXC_ADDR_ERR_EN
   input  logic        adel_i,
   input  logic        ades_i,
`endif
   input  logic        syscall_i,
   input  logic        inst_invalid_i,
   input  logic        ov_i,
   input  logic        eret_i,
   output logic        take_o,
   output logic        is_eret_o,
   output logic [4:0]  exccode_o,
   output logic [31:0] excepttype_o
);

   always_comb begin
      take_o       = 1'b1;
      is_eret_o    = 1'b0;
      exccode_o    = ExcCodeInt;
      excepttype_o = '0;
      if (int_pending_i) begin
         exccode_o    = ExcCodeInt;
         excepttype_o = ExcTypeInt;
`ifdef EXC_ADDR_ERR_EN
      end else if (adel_i) begin
         exccode_o    = ExcCodeAdel;
         excepttype_o = ExcTypeAdel;
      end else if (ades_i) begin
         exccode_o    = ExcCodeAdes;
         excepttype_o = ExcTypeAdes;
`endif
      end else if (syscall_i) begin
         exccode_o    = ExcCodeSys;
         excepttype_o = ExcTypeSys;
      end else if (inst_invalid_i) begin
         exccode_o    = ExcCodeRi;
         excepttype_o = ExcTypeRi;
      end else if (ov_i) begin
         exccode_o    = ExcCodeOv;
         excepttype_o = ExcTypeOv;
      end else if (eret_i) begin
         is_eret_o    = 1'b1;
         excepttype_o = ExcTypeEret;
      end else begin
         take_o = 1'b0;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller: forwards CP0 from WB, picks the
// highest-priority event and emits a one-cycle registered flush and CP0 update.
// Optional address-error support is enabled with EXC_ADDR_ERR_EN.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = ExcVectorDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic        syscall_i,
   input  logic        inst_invalid_i,
   input  logic        ov_i,
   input  logic        eret_i,
`ifdef EXC_ADDR_ERR_EN
   input  logic        adel_i,
   input  logic        ades_i,
`endif
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic [31:0] excepttype_o,
   output logic        cp0_exc_we_o,
   output logic [31:0] cp0_epc_o,
   output logic [4:0]  cp0_exccode_o,
   output logic        cp0_bd_o,
   output logic        cp0_set_exl_o,
   output logic        cp0_clr_exl_o
);

   exc_state_e  state_q, state_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [31:0] exctype_q, exctype_d;
   logic        we_q, we_d;
   logic [31:0] epc_q, epc_d;
   logic [4:0]  exccode_q, exccode_d;
   logic        bd_q, bd_d;
   logic        set_exl_q, set_exl_d;
   logic        clr_exl_q, clr_exl_d;

   logic [31:0] status_fwd, cause_fwd, epc_fwd;
   logic        int_pending;
   logic        take, is_eret;
   logic [4:0]  enc_exccode;
   logic [31:0] enc_type;
   logic        unused_cp0;

   // Only the software-writable Cause fields (IV, WP, IP1:0) are forwarded.
   always_comb begin
      status_fwd = cp0_status_i;
      cause_fwd  = cp0_cause_i;
      epc_fwd    = cp0_epc_i;
      if (wb_cp0_we_i) begin
         unique case (wb_cp0_waddr_i)
            Cp0RegStatus: status_fwd = wb_cp0_data_i;
            Cp0RegCause: begin
               cause_fwd[23]  = wb_cp0_data_i[23];
               cause_fwd[22]  = wb_cp0_data_i[22];
               cause_fwd[9:8] = wb_cp0_data_i[9:8];
            end
            Cp0RegEpc:   epc_fwd = wb_cp0_data_i;
            default:     ;
         endcase
      end
   end

   assign int_pending = status_fwd[0] && !status_fwd[1] &&
                        ((cause_fwd[15:8] & status_fwd[15:8]) != 8'h00);

   assign unused_cp0 = ^{status_fwd[31:16], status_fwd[7:2],
                         cause_fwd[31:16], cause_fwd[7:0]};

   exc_prio_enc u_prio_enc (
      .int_pending_i  (int_pending),
`ifdef EXC_ADDR_ERR_EN
      .adel_i         (adel_i),
      .ades_i         (ades_i),
`endif
      .syscall_i      (syscall_i),
      .inst_invalid_i (inst_invalid_i),
      .ov_i           (ov_i),
      .eret_i         (eret_i),
      .take_o         (take),
      .is_eret_o      (is_eret),
      .exccode_o      (enc_exccode),
      .excepttype_o   (enc_type)
   );

   always_comb begin
      state_d   = state_q;
      flush_d   = 1'b0;
      new_pc_d  = '0;
      exctype_d = '0;
      we_d      = 1'b0;
      epc_d     = '0;
      exccode_d = '0;
      bd_d      = 1'b0;
      set_exl_d = 1'b0;
      clr_exl_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mem_valid_i && take) begin
               state_d   = StFlush;
               flush_d   = 1'b1;
               we_d      = 1'b1;
               exctype_d = enc_type;
               if (is_eret) begin
                  new_pc_d  = epc_fwd;
                  clr_exl_d = 1'b1;
               end else begin
                  new_pc_d  = EXC_VECTOR;
                  epc_d     = exc_epc(mem_pc_i, mem_in_delayslot_i);
                  exccode_d = enc_exccode;
                  bd_d      = mem_in_delayslot_i;
                  set_exl_d = 1'b1;
               end
            end
         end
         // The MEM instruction is being squashed, so nothing is detected here.
         StFlush: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         state_q   <= StIdle;
         flush_q   <= 1'b0;
         new_pc_q  <= '0;
         exctype_q <= '0;
         we_q      <= 1'b0;
         epc_q     <= '0;
         exccode_q <= '0;
         bd_q      <= 1'b0;
         set_exl_q <= 1'b0;
         clr_exl_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flush_q   <= flush_d;
         new_pc_q  <= new_pc_d;
         exctype_q <= exctype_d;
         we_q      <= we_d;
         epc_q     <= epc_d;
         exccode_q <= exccode_d;
         bd_q      <= bd_d;
         set_exl_q <= set_exl_d;
         clr_exl_q <= clr_exl_d;
      end
   end

   assign flush_o       = flush_q;
   assign new_pc_o      = new_pc_q;
   assign excepttype_o  = exctype_q;
   assign cp0_exc_we_o  = we_q;
   assign cp0_epc_o     = epc_q;
   assign cp0_exccode_o = exccode_q;
   assign cp0_bd_o      = bd_q;
   assign cp0_set_exl_o = set_exl_q;
   assign cp0_clr_exl_o = clr_exl_q;

endmodule
